act_quant_pack: RTL and testbench

- Multi-lane successor to the single-value activation quantizer.
- Takes LANES wide accumulator results per beat and quantises each to a 2/4/8-bit signed value, using a power-of-2 shift with a leaky (extra-shift) path for negatives, optional rounding and symmetric saturation.
- Packs the results densely into OUT_WIDTH-bit words for the activation write-back buffer, with valid/ready flow control, flush and a saturation counter.

---
 rtl/act_quant_pack_if.sv | 25 ++
 rtl/act_quant_pack.sv | 166 ++++++++++++++++
 tb/tb_act_quant_pack.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/act_quant_pack_if.sv
// act_quant_pack_if: beat-in / word-out handshake bundle for act_quant_pack.
//   din/vld_i/rdy_o/flush_i : input beats (LANES x DATA_WIDTH signed) plus the flush sideband
//   data_o/vld_o/rdy_i      : packed LANES*8-bit output words with valid/ready
//   partial_o               : word was closed before it was full
// Modports: slave is the quantiser's view, master is the producer/consumer view.
interface act_quant_pack_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 29
);
  localparam int OUT_WIDTH = LANES * 8;

  logic [LANES*DATA_WIDTH-1:0] din;
  logic                        vld_i;
  logic                        rdy_o;
  logic                        flush_i;
  logic [OUT_WIDTH-1:0]        data_o;
  logic                        vld_o;
  logic                        rdy_i;
  logic                        partial_o;

  modport slave  (input  din, vld_i, flush_i, rdy_i,
                  output rdy_o, data_o, vld_o, partial_o);
  modport master (output din, vld_i, flush_i, rdy_i,
                  input  rdy_o, data_o, vld_o, partial_o);
endinterface

// File: rtl/act_quant_pack.sv
// act_quant_pack: multi-lane activation quantiser and dense packer.
// Each accepted beat carries LANES signed values. Every lane is right-shifted
// (an extra LEAKY_SHIFT for negatives when linear=0), optionally rounded half up,
// clamped symmetrically to 2/4/8 bits, and packed LSB-first into LANES*8-bit words.
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   bus (slave)     din/vld_i/rdy_o/flush_i in, data_o/vld_o/rdy_i/partial_o out
//   fmap_precision  0:2-bit 1:4-bit 2,3:8-bit
//   shift, linear, round_en   quantiser controls, captured with each beat
//   sat_cnt, cnt_clr          saturating count of clamped lanes, synchronous clear
// Pipeline: s0 (accepted raw beat) -> s1 (quantised beat) -> packer/output register,
// all moving on one global advance, giving vld_o two edges after acceptance.
module act_quant_pack #(
  parameter int LANES       = 4,
  parameter int DATA_WIDTH  = 29,
  parameter int SHIFT_WIDTH = 4,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  act_quant_pack_if.slave        bus,
  input  logic [1:0]             fmap_precision,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   linear,
  input  logic                   round_en,
  input  logic                   cnt_clr,
  output logic [CNT_WIDTH-1:0]   sat_cnt
);
  localparam int OUT_WIDTH = LANES * 8;
  // Wide enough that shift, bias add and clamp compares never wrap.
  localparam int FW  = DATA_WIDTH + (1 << SHIFT_WIDTH) + LEAKY_SHIFT;
  localparam int SCW = $clog2(LANES + 1);
  localparam logic [FW-1:0] ONE = FW'(1);

  logic                        s0_vld, s0_flush, s0_linear, s0_round;
  logic [LANES*DATA_WIDTH-1:0] s0_din;
  logic [1:0]                  s0_prec;
  logic [SHIFT_WIDTH-1:0]      s0_shift;
  logic                        s1_vld, s1_flush;
  logic [OUT_WIDTH-1:0]        s1_q;
  logic [1:0]                  s1_prec;
  logic [OUT_WIDTH-1:0]        acc;
  logic [1:0]                  ptr, acc_prec;

  logic                        advance, hold, move;
  logic [OUT_WIDTH-1:0]        q_lanes, merged;
  logic [SCW-1:0]              sat_lanes;
  logic [CNT_WIDTH:0]          sat_sum;
  logic                        last;

  always_comb begin
    logic signed [FW-1:0] x, q, maxv;
    logic [FW-1:0]        pw, bias;
    int                   e;
    q_lanes   = '0;
    sat_lanes = '0;
    x = '0; q = '0; pw = '0; bias = '0; e = 0;
    case (s0_prec)
      2'd0:    maxv = FW'(1);
      2'd1:    maxv = FW'(7);
      default: maxv = FW'(127);
    endcase
    for (int i = 0; i < LANES; i++) begin
      x = FW'(signed'(s0_din[i*DATA_WIDTH +: DATA_WIDTH]));
      e = int'(s0_shift) + ((x < 0 && !s0_linear) ? LEAKY_SHIFT : 0);
      pw = ONE << e;
      // Rounding adds half an LSB; truncation of negatives adds 2^e-1 so the
      // arithmetic shift lands on ceil (toward zero).
      if (s0_round)  bias = pw >> 1;
      else if (x < 0) bias = pw - ONE;
      else           bias = '0;
      q = (x + signed'(bias)) >>> e;
      if (q > maxv) begin
        q = maxv;
        sat_lanes = sat_lanes + SCW'(1);
      end else if (q < -maxv) begin
        q = -maxv;
        sat_lanes = sat_lanes + SCW'(1);
      end
      q_lanes[i*8 +: 8] = q[7:0];
    end
  end

  always_comb begin
    logic [OUT_WIDTH-1:0] beat;
    int                   pbits;
    beat = '0;
    case (s1_prec)
      2'd0:    pbits = 2;
      2'd1:    pbits = 4;
      default: pbits = 8;
    endcase
    for (int i = 0; i < LANES; i++) begin
      case (s1_prec)
        2'd0:    beat[i*2 +: 2] = s1_q[i*8 +: 2];
        2'd1:    beat[i*4 +: 4] = s1_q[i*8 +: 4];
        default: beat[i*8 +: 8] = s1_q[i*8 +: 8];
      endcase
    end
    merged = acc | (beat << (int'(ptr) * LANES * pbits));
    last   = ((int'(ptr) + 1) * pbits) == 8;
  end

  // A beat whose precision differs from the open word stalls one cycle while
  // the open word is closed out as partial.
  assign hold       = s1_vld && (ptr != 2'd0) && (s1_prec != acc_prec);
  assign advance    = !bus.vld_o || bus.rdy_i;
  assign move       = advance && !hold;
  assign bus.rdy_o  = rstn && move;
  assign sat_sum    = {1'b0, sat_cnt} + {{(CNT_WIDTH + 1 - SCW){1'b0}}, sat_lanes};

  // flush_i is sampled only while rdy_o is high; a flush with no beat travels
  // the pipeline as a token so it closes the word after earlier beats land.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s0_vld <= 1'b0; s0_flush <= 1'b0; s0_din <= '0; s0_prec <= 2'd2;
      s0_shift <= '0; s0_linear <= 1'b1; s0_round <= 1'b0;
      s1_vld <= 1'b0; s1_flush <= 1'b0; s1_q <= '0; s1_prec <= 2'd2;
    end else if (move) begin
      s0_vld    <= bus.vld_i;
      s0_flush  <= bus.flush_i;
      s0_din    <= bus.din;
      s0_prec   <= (fmap_precision == 2'd3) ? 2'd2 : fmap_precision;
      s0_shift  <= shift;
      s0_linear <= linear;
      s0_round  <= round_en;
      s1_vld    <= s0_vld;
      s1_flush  <= s0_flush;
      s1_q      <= q_lanes;
      s1_prec   <= s0_prec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || cnt_clr)
      sat_cnt <= '0;
    else if (move && s0_vld)
      sat_cnt <= sat_sum[CNT_WIDTH] ? '1 : sat_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0; ptr <= 2'd0; acc_prec <= 2'd2;
      bus.data_o <= '0; bus.vld_o <= 1'b0; bus.partial_o <= 1'b0;
    end else if (advance) begin
      bus.vld_o     <= 1'b0;
      bus.partial_o <= 1'b0;
      if (hold) begin
        bus.data_o <= acc; bus.vld_o <= 1'b1; bus.partial_o <= 1'b1;
        acc <= '0; ptr <= 2'd0;
      end else if (s1_vld) begin
        if (ptr == 2'd0) acc_prec <= s1_prec;
        if (last || s1_flush) begin
          bus.data_o <= merged; bus.vld_o <= 1'b1; bus.partial_o <= !last;
          acc <= '0; ptr <= 2'd0;
        end else begin
          acc <= merged; ptr <= ptr + 2'd1;
        end
      end else if (s1_flush && ptr != 2'd0) begin
        bus.data_o <= acc; bus.vld_o <= 1'b1; bus.partial_o <= 1'b1;
        acc <= '0; ptr <= 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_act_quant_pack.sv
// Directed bench for act_quant_pack: hand-computed words, a backpressure
// scoreboard, precision switch, flush, counter saturation/clear and reset.
module tb_act_quant_pack;
  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  fmap_precision;
  logic [3:0]  shift;
  logic        linear, round_en, cnt_clr;
  logic [15:0] sat_cnt;
  int          n_asrt = 0;
  int          n_fail = 0;

  act_quant_pack_if #(.LANES(4), .DATA_WIDTH(29)) bus ();

  act_quant_pack dut (
    .clk(clk), .rstn(rstn), .bus(bus), .fmap_precision(fmap_precision),
    .shift(shift), .linear(linear), .round_en(round_en),
    .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  function automatic logic [115:0] mk(input int a, input int b, input int c, input int d);
    return {29'(d), 29'(c), 29'(b), 29'(a)};
  endfunction

  function automatic logic [31:0] exp8(input int k);
    logic [7:0] a, b, c, d;
    a = 8'(k); b = 8'(k + 1); c = 8'(-k); d = 8'(2 * k);
    return {d, c, b, a};
  endfunction

  task automatic send(input logic [115:0] d, input logic fl);
    int k;
    bus.din = d; bus.vld_i = 1'b1; bus.flush_i = fl; #1;
    k = 0;
    while (!bus.rdy_o && k < 50) begin tick(); k++; end
    chk("send_accept", k < 50, 1);
    @(posedge clk); #2;
    bus.vld_i = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    int k;
    k = 0;
    while (!bus.vld_o && k < 20) begin tick(); k++; end
    chk({tag, "_vld"}, bus.vld_o, 1);
  endtask

  task automatic pulse_flush();
    bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
  endtask

  task automatic count_vld(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin tick(); if (bus.vld_o) seen++; end
    chk(tag, seen, 0);
  endtask

  initial begin
    logic [115:0] pd[4];
    logic [1:0]   pp[4];
    logic [31:0]  ew[4], wd[4], prev_data;
    logic         ep[4], pf[4], fire, stalled_prev;
    int           sent, got, idx, nw, low;

    rstn = 1'b0; cnt_clr = 1'b0; fmap_precision = 2'd2; shift = 4'd0;
    linear = 1'b1; round_en = 1'b0;
    bus.din = '0; bus.vld_i = 1'b0; bus.flush_i = 1'b0; bus.rdy_i = 1'b1;
    tick(); tick();
    chk("rst_vld_o", bus.vld_o, 0);
    chk("rst_data_o", bus.data_o, 0);
    chk("rst_partial_o", bus.partial_o, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_rdy_o", bus.rdy_o, 0);
    rstn = 1'b1;
    tick();

    // 8-bit, s=2, linear, truncate: {600,20,-9,-1000} -> {127,5,-2,-127}
    fmap_precision = 2'd2; shift = 4'd2; linear = 1'b1; round_en = 1'b0;
    send(mk(600, 20, -9, -1000), 1'b0);
    chk("t1_lat_edge_t", bus.vld_o, 0);
    tick();
    chk("t1_lat_edge_t1", bus.vld_o, 0);
    tick();
    chk("t1_lat_edge_t2", bus.vld_o, 1);
    chk("t1_data", bus.data_o, 32'h81FE057F);
    chk("t1_partial", bus.partial_o, 0);
    chk("t1_sat_cnt", sat_cnt, 2);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("t1_cnt_clr", sat_cnt, 0);

    // 4-bit, leaky (e=4 for negatives), round: {-24,3,15,100} -> {-1,2,7,7}
    fmap_precision = 2'd1; shift = 4'd1; linear = 1'b0; round_en = 1'b1;
    send(mk(-24, 3, 15, 100), 1'b0);
    send(mk(-24, 3, 15, 100), 1'b0);
    wait_vld("t2");
    chk("t2_data", bus.data_o, 32'h772F772F);
    chk("t2_partial", bus.partial_o, 0);
    chk("t2_sat_cnt", sat_cnt, 4);
    tick();

    // 2-bit, three beats then a bare flush -> partial word, upper byte zero
    fmap_precision = 2'd0; shift = 4'd0; linear = 1'b1; round_en = 1'b0;
    send(mk(1, 0, -1, 1), 1'b0);
    send(mk(5, -5, 0, 0), 1'b0);
    send(mk(-1, -1, -1, -1), 1'b0);
    pulse_flush();
    wait_vld("t3");
    chk("t3_data", bus.data_o, 32'h00FF0D71);
    chk("t3_partial", bus.partial_o, 1);
    tick();
    pulse_flush();
    count_vld("t3_empty_flush", 8);

    // Backpressure: rdy_i low for 5 cycles while 8-bit beats stream
    fmap_precision = 2'd2; shift = 4'd0; linear = 1'b1; round_en = 1'b0;
    sent = 0; got = 0; stalled_prev = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      bus.rdy_i = !(cyc >= 4 && cyc < 9);
      bus.vld_i = (sent < 10);
      bus.din   = mk(sent, sent + 1, -sent, 2 * sent);
      #1;
      if (bus.vld_o && stalled_prev) chk("bp_hold", bus.data_o, prev_data);
      if (bus.vld_o && !bus.rdy_i) chk("bp_rdy_o", bus.rdy_o, 0);
      fire = bus.vld_i && bus.rdy_o;
      if (bus.vld_o && bus.rdy_i) begin
        chk("bp_word", bus.data_o, exp8(got));
        got++;
      end
      stalled_prev = bus.vld_o && !bus.rdy_i;
      prev_data    = bus.data_o;
      @(posedge clk); #2;
      if (fire) sent++;
    end
    bus.vld_i = 1'b0; bus.rdy_i = 1'b1;
    chk("bp_words_out", got, 10);
    chk("bp_beats_in", sent, 10);
    tick(); tick();

    // Precision switch 4-bit -> 8-bit after one beat
    pd[0] = mk(1, 2, 3, -1);    pp[0] = 2'd1; ew[0] = 32'h0000F321; ep[0] = 1'b1;
    pd[1] = mk(10, 20, 30, 40); pp[1] = 2'd2; ew[1] = 32'h281E140A; ep[1] = 1'b0;
    pd[2] = mk(-3, 0, 0, 0);    pp[2] = 2'd2; ew[2] = 32'h000000FD; ep[2] = 1'b0;
    pd[3] = mk(4, 0, 0, 0);     pp[3] = 2'd2; ew[3] = 32'h00000004; ep[3] = 1'b0;
    idx = 0; nw = 0; low = 0;
    for (int cyc = 0; cyc < 30 && nw < 4; cyc++) begin
      bus.vld_i = (idx < 4);
      if (idx < 4) begin bus.din = pd[idx]; fmap_precision = pp[idx]; end
      #1;
      if (bus.vld_i && !bus.rdy_o) low++;
      fire = bus.vld_i && bus.rdy_o;
      if (bus.vld_o) begin wd[nw] = bus.data_o; pf[nw] = bus.partial_o; nw++; end
      @(posedge clk); #2;
      if (fire) idx++;
    end
    bus.vld_i = 1'b0;
    chk("ps_word_count", nw, 4);
    chk("ps_rdy_drop_cycles", low, 1);
    for (int i = 0; i < 4; i++) begin
      chk("ps_word", wd[i], ew[i]);
      chk("ps_partial", pf[i], ep[i]);
    end

    // sat_cnt saturation under continuous 4-lane clamp, then clear on a clamp
    fmap_precision = 2'd0; shift = 4'd0; linear = 1'b1; round_en = 1'b0;
    bus.din = mk(100, 100, 100, 100); bus.vld_i = 1'b1;
    repeat (16400) @(posedge clk);
    #2;
    chk("sat_stick", sat_cnt, 16'hFFFF);
    tick();
    chk("sat_stick_again", sat_cnt, 16'hFFFF);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    chk("sat_clr_over_clamp", sat_cnt, 0);
    bus.vld_i = 1'b0;
    repeat (4) tick();
    chk("sat_after_clr", sat_cnt, 4);

    // Reset with a partial word held: nothing emitted, pointer cleared
    pulse_flush();
    repeat (5) tick();
    send(mk(1, 1, 1, 1), 1'b0);
    count_vld("rst_partial_no_emit", 5);
    rstn = 1'b0; tick(); rstn = 1'b1;
    chk("rst_mid_vld_o", bus.vld_o, 0);
    chk("rst_mid_sat_cnt", sat_cnt, 0);
    tick();
    chk("rst_mid_vld_o_next", bus.vld_o, 0);
    pulse_flush();
    count_vld("rst_mid_flush_empty", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
